apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB slave register file that sits directly downstream of `APB_master`, consuming its `psel`/`penable`/`paddr`/`pwrite`/`pwdata` transfers and returning `prdata`/`pready`. It provides `NUM_REGS` read/write data registers and one read-only write-completion counter. Wait-state insertion is programmable. Unmapped addresses complete with `pslverr`.

## Interface
- `DATA_W`, 8: data bus width.
- `ADDR_W`, 8: address bus width.
- `NUM_REGS`, 16: RW registers at addresses 0..NUM_REGS-1; legal range 1..128.
- `WAIT_STATES`, 1: pready-low access cycles before completion; legal range 0..15.
- `CNT_ADDR`, 8'hF0: address of the read-only write counter; must be ≥ NUM_REGS.

Ports:
- `pclk`  in  1  clock; all logic on the rising edge.
- `prst`  in  1  reset; synchronous, active-high.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_W  transfer address.
- `pwdata`  in  DATA_W  write data.
- `prdata`  out  DATA_W  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer completes in this cycle.
- `pslverr`  out  1  error response; valid only while `pready`=1.

## Operation
- All outputs are registered.
- Reset values:
  - `prdata`=0, `pready`=0, `pslverr`=0.
  - All data registers = 0; write counter = 0.
  - FSM = IDLE; wait counter = 0.
- FSM states:
  - **IDLE**:
    - On `psel`=1, `penable`=0 (setup cycle): latch `paddr` and `pwrite`, load wait counter with `WAIT_STATES`, go to ACCESS.
    - If `WAIT_STATES`=0, set `pready`=1 on this same edge.
    - `psel`=1 with `penable`=1 in IDLE (protocol error) is ignored.
  - **ACCESS**:
    - Each cycle with `psel`=1, `penable`=1 and `pready`=0: decrement the wait counter. Set `pready`=1 on the edge where it reaches 0.
    - On the edge ending a cycle with `pready`=1: commit the write (if any), clear `pready` and `pslverr`, go to IDLE.
  - **Abort**: if `psel`=0 at any edge in ACCESS, go to IDLE, clear `pready`, discard the transfer. No register or counter change.
- Address decode uses the latched address:
  - addr < `NUM_REGS`: RW register.
  - addr == `CNT_ADDR`: read returns the counter. A write there is an error.
  - Any other address: error.
- Read data: loaded into `prdata` on the same edge that raises `pready`. `prdata` returns to 0 when `pready` falls.
- Errors: `pslverr`=1 together with `pready`; `prdata`=0; no register write; counter not incremented.
- Write commit: target register ← `pwdata` sampled in the completing cycle. Counter increments by 1 (DATA_W bits, wraps 0xFF→0x00) on every successful write.
- `paddr`/`pwrite` changes during ACCESS are ignored. `pwdata` is sampled only at commit.

## Timing
- Setup cycle T0, first access cycle T1.
  - `pready` is high during cycle T1+`WAIT_STATES`.
  - Transfer length = 2 + `WAIT_STATES` cycles (`WAIT_STATES`=0 → 2 cycles, `WAIT_STATES`=1 → 3 cycles).
- `pready` is high for exactly one cycle per transfer.
- Back-to-back: a setup cycle immediately after the completion cycle is accepted. The slave is in IDLE that cycle, so there is no dead cycle.
- Read-after-write to the same address returns the new value: the write commits before the next setup cycle.
- `prst` asserted mid-transfer: the next edge applies reset values; the pending write is lost.
- Simultaneous `prst` and setup: reset wins; the setup is ignored.

## Test plan
- Reset: hold `prst`=1 for 2 cycles → `pready`=0, `pslverr`=0, `prdata`=0. Reads of addresses 0..15 then return 0x00 and the counter reads 0x00.
- Write/read with `WAIT_STATES`=1: write 0x02 to addr 0x01 → `pready` high exactly in the 3rd cycle. Then read addr 0x01 → `prdata`=0x02 with `pready`, `pslverr`=0. Counter reads 0x01.
- Error paths:
  - Write 0x05 to addr 0x20 → `pslverr`=1 with `pready`; reg contents and counter unchanged.
  - Write to 0xF0 → `pslverr`=1; counter unchanged.
- Back-to-back writes: 0x03→addr 0x02 then 0x04→addr 0x04 with no idle cycle → both commit. Counter = 2. Reads return 0x03 and 0x04.
- Abort and reset:
  - Drop `psel` during a wait state of a write to addr 0x00 → no `pready`; addr 0x00 keeps its prior value.
  - Assert `prst` mid-transfer → all outputs 0 next cycle; registers cleared.
- Counter wrap: 256 successful writes → counter reads 0x00. `WAIT_STATES`=0 build: every transfer completes in 2 cycles.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS read/write data registers plus a
// read-only counter of successful writes. Each transfer inserts
// WAIT_STATES pready-low access cycles before completing. Addresses outside
// the map complete with pslverr. All outputs are registered.
module apb_slave_regfile #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1,
  parameter int CNT_ADDR    = 'hF0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int                IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] CNT_A   = ADDR_W'(CNT_ADDR);
  localparam logic [3:0]        WS_INIT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_n;
  logic [3:0]        wcnt, wcnt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              write_q, write_n;
  logic              pready_n, pslverr_n;
  logic [DATA_W-1:0] prdata_n;
  logic              commit;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wr_cnt;

  logic [ADDR_W-1:0] dec_addr;
  logic              dec_write;
  logic              dec_err;
  logic [DATA_W-1:0] dec_rdata;

  function automatic logic is_reg(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  // Decode the transfer that is about to complete. In IDLE (only reachable
  // with zero wait states) the setup-cycle bus is used directly because the
  // latch happens on the same edge that raises pready.
  always_comb begin
    dec_addr  = (state == IDLE) ? paddr  : addr_q;
    dec_write = (state == IDLE) ? pwrite : write_q;
    dec_err   = 1'b1;
    dec_rdata = '0;
    if (is_reg(dec_addr)) begin
      dec_err = 1'b0;
      if (!dec_write) dec_rdata = regs[reg_idx(dec_addr)];
    end else if ((dec_addr == CNT_A) && !dec_write) begin
      dec_err   = 1'b0;
      dec_rdata = wr_cnt;
    end
  end

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    addr_n    = addr_q;
    write_n   = write_q;
    pready_n  = pready;
    pslverr_n = pslverr;
    prdata_n  = prdata;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        // psel with penable in IDLE is a protocol error and is ignored.
        if (psel && !penable) begin
          state_n = ACCESS;
          addr_n  = paddr;
          write_n = pwrite;
          wcnt_n  = WS_INIT;
          if (WAIT_STATES == 0) begin
            pready_n  = 1'b1;
            pslverr_n = dec_err;
            prdata_n  = dec_rdata;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: nothing is committed.
          state_n   = IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
          prdata_n  = '0;
        end else if (pready) begin
          commit    = write_q && !pslverr && is_reg(addr_q);
          state_n   = IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
          prdata_n  = '0;
        end else if (penable) begin
          wcnt_n = (wcnt != 4'd0) ? (wcnt - 4'd1) : 4'd0;
          if (wcnt <= 4'd1) begin
            pready_n  = 1'b1;
            pslverr_n = dec_err;
            prdata_n  = dec_rdata;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, latched transfer attributes and registered outputs.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      addr_q  <= addr_n;
      write_q <= write_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
      prdata  <= prdata_n;
    end
  end

  // Register file and write counter; a write lands on the completing edge.
  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_cnt <= '0;
    end else if (commit) begin
      regs[reg_idx(addr_q)] <= pwdata;
      wr_cnt                <= wr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: one instance with one wait state
// and one with zero wait states, driven by directed transfers.
module tb_apb_slave_regfile;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic       prst;
  logic       psel0, penable0, pwrite0, pready0, pslverr0;
  logic [7:0] paddr0, pwdata0, prdata0;
  logic       psel1, penable1, pwrite1, pready1, pslverr1;
  logic [7:0] paddr1, pwdata1, prdata1;

  apb_slave_regfile #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(1), .CNT_ADDR('hF0)) u_ws1 (
    .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
    .paddr(paddr0), .pwdata(pwdata0), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_slave_regfile #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(0), .CNT_ADDR('hF0)) u_ws0 (
    .pclk(pclk), .prst(prst), .psel(psel1), .penable(penable1), .pwrite(pwrite1),
    .paddr(paddr1), .pwdata(pwdata1), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  typedef struct {
    int         start;
    int         lat;
    logic       err;
    logic       chk_data;
    logic [7:0] data;
    string      nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic e, input logic w,
                       input logic [7:0] a, input logic [7:0] wd);
    if (d == 0) begin
      psel0 = s; penable0 = e; pwrite0 = w; paddr0 = a; pwdata0 = wd;
    end else begin
      psel1 = s; penable1 = e; pwrite1 = w; paddr1 = a; pwdata1 = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    drive(d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (n) tick();
  endtask

  // One complete transfer; the expected response goes to the scoreboard.
  // The address is inverted during the access phase, which must be ignored.
  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input logic err, input logic [7:0] rd, input string nm);
    exp_t e;
    bit   done;
    e.start    = cyc;
    e.lat      = (d == 0) ? 2 : 1;
    e.err      = err;
    e.chk_data = !w || err;
    e.data     = rd;
    e.nm       = nm;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive(d, 1'b1, 1'b0, w, a, wd);
    tick();
    drive(d, 1'b1, 1'b1, w, ~a, wd);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge pclk);
      done = rdy(d);
      tick();
    end
    chk({nm, " completion"}, 32'(done), 32'd1);
  endtask

  task automatic mon(input int d);
    logic       r, se;
    logic [7:0] pd;
    exp_t       e;
    int         sz;
    r  = (d == 0) ? pready0  : pready1;
    se = (d == 0) ? pslverr0 : pslverr1;
    pd = (d == 0) ? prdata0  : prdata1;
    sz = (d == 0) ? q0.size() : q1.size();
    if (r) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected pready at cycle %0d: got 1 expected 0", d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({e.nm, " latency"}, 32'(cyc - e.start), 32'(e.lat));
        chk({e.nm, " pslverr"}, 32'(se), 32'(e.err));
        if (e.chk_data) chk({e.nm, " prdata"}, 32'(pd), 32'(e.data));
      end
    end else begin
      chk($sformatf("dut%0d idle prdata", d), 32'(pd), 32'd0);
      chk($sformatf("dut%0d idle pslverr", d), 32'(se), 32'd0);
    end
  endtask

  always @(negedge pclk) begin
    if (mon_en) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) tick();
    chk("reset pready0",  32'(pready0),  32'd0);
    chk("reset pslverr0", 32'(pslverr0), 32'd0);
    chk("reset prdata0",  32'(prdata0),  32'd0);
    chk("reset pready1",  32'(pready1),  32'd0);
    chk("reset pslverr1", 32'(pslverr1), 32'd0);
    chk("reset prdata1",  32'(prdata1),  32'd0);
    prst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Fresh register file and counter read as zero.
    for (int a = 0; a < 16; a++) xfer(0, 1'b0, 8'(a), 8'h00, 1'b0, 8'h00, $sformatf("rst read %0d", a));
    xfer(0, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, "rst cnt");
    idle(0, 1);

    // Basic write then read-back with one wait state.
    xfer(0, 1'b1, 8'h01, 8'h02, 1'b0, 8'h00, "wr 01");
    idle(0, 1);
    xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h02, "rd 01");
    xfer(0, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h01, "cnt 1");
    idle(0, 2);

    // Error paths and map boundaries.
    xfer(0, 1'b1, 8'h20, 8'h05, 1'b1, 8'h00, "wr unmapped");
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00, "rd unmapped");
    xfer(0, 1'b1, 8'hF0, 8'h09, 1'b1, 8'h00, "wr cnt");
    xfer(0, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h01, "cnt after errs");
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h00, "rd NUM_REGS");
    xfer(0, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h00, "rd last reg");
    xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h02, "rd 01 kept");
    idle(0, 1);

    // Back-to-back writes, then read-after-write with no gap.
    xfer(0, 1'b1, 8'h02, 8'h03, 1'b0, 8'h00, "b2b wr 02");
    xfer(0, 1'b1, 8'h04, 8'h04, 1'b0, 8'h00, "b2b wr 04");
    xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 8'h03, "b2b rd 02");
    xfer(0, 1'b0, 8'h04, 8'h00, 1'b0, 8'h04, "b2b rd 04");
    xfer(0, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h03, "cnt 3");
    xfer(0, 1'b1, 8'h05, 8'hC3, 1'b0, 8'h00, "raw wr 05");
    xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 8'hC3, "raw rd 05");
    xfer(0, 1'b1, 8'h00, 8'hAA, 1'b0, 8'h00, "wr 00");
    idle(0, 1);

    // Abort: psel drops during the wait state of a write to 0x00.
    drive(0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55);
    tick();
    idle(0, 3);
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hAA, "abort rd 00");
    xfer(0, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h05, "abort cnt");
    idle(0, 1);

    // Reset in the middle of a write transfer.
    drive(0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h77);
    tick();
    drive(0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h77);
    prst = 1'b1;
    tick();
    chk("midrst pready0",  32'(pready0),  32'd0);
    chk("midrst pslverr0", 32'(pslverr0), 32'd0);
    chk("midrst prdata0",  32'(prdata0),  32'd0);
    prst = 1'b0;
    idle(0, 1);
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "midrst rd 00");
    xfer(0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, "midrst rd 03");
    xfer(0, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, "midrst cnt");
    idle(0, 1);

    // Reset together with a setup cycle: the setup must be dropped.
    prst = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h11);
    tick();
    prst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h11);
    tick();
    idle(0, 2);
    xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, "rstsetup rd 01");
    idle(0, 1);

    // Zero-wait-state instance: two-cycle transfers and counter wrap.
    xfer(1, 1'b1, 8'h07, 8'h5A, 1'b0, 8'h00, "ws0 wr 07");
    xfer(1, 1'b0, 8'h07, 8'h00, 1'b0, 8'h5A, "ws0 rd 07");
    xfer(1, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h01, "ws0 cnt 1");
    xfer(1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h00, "ws0 rd unmapped");
    for (int i = 1; i < 256; i++) xfer(1, 1'b1, 8'(i % 16), 8'(i), 1'b0, 8'h00, $sformatf("ws0 wr #%0d", i));
    xfer(1, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, "ws0 cnt wrap");
    xfer(1, 1'b0, 8'h0F, 8'h00, 1'b0, 8'hFF, "ws0 rd 0F");
    xfer(1, 1'b0, 8'h07, 8'h00, 1'b0, 8'hF7, "ws0 rd 07 last");
    idle(1, 3);

    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
